// File: rtl/i2si_pkg.sv
// i2si_pkg: mode constants, FSM state encoding and counter-width helper for the I2S input deserializer.
package i2si_pkg;
  localparam logic I2SI_MODE_I2S = 1'b0;
  localparam logic I2SI_MODE_LJ  = 1'b1;
  typedef enum logic [1:0] {IDLE, SYNC, RUN_L, RUN_R} i2si_state_e;
  function automatic int i2si_cnt_w(input int slot_w);
    return $clog2(slot_w + 2);
  endfunction
endpackage

// File: rtl/i2si_slot_capture.sv
// i2si_slot_capture: slot bit counter, MSB-first shift register and word-done strobe.
// I2SI_FRAME_CHECK_EN adds the slot-length status bad_o.
module i2si_slot_capture
  import i2si_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              smp_i,
  input  logic              sd_i,
  input  logic              start_i,
  input  logic              lj_i,
  output logic              done_o,
  output logic              bad_o,
  output logic [DATA_W-1:0] word_o
);
  localparam int CW = i2si_cnt_w(SLOT_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] SAT = CW'(SLOT_W + 1);
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [DATA_W-1:0] sr_q, sr_d;
  // in LJ mode the WS-edge sample is bit 0 of the new slot; in I2S it closes the old one
  always_comb begin
    idx    = (start_i && lj_i) ? '0 : cnt_q;
    word_o = {sr_q[DATA_W-2:0], sd_i};
    done_o = smp_i && idx == LAST;
    sr_d   = clr_i ? '0 : (smp_i && idx <= LAST) ? word_o : sr_q;
    cnt_d  = clr_i ? '0 : !smp_i ? cnt_q : start_i ? CW'(lj_i) : (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
  end
`ifdef I2SI_FRAME_CHECK_EN
  localparam logic [CW-1:0] SLOT = CW'(SLOT_W);
  assign bad_o = smp_i && (start_i ? cnt_q != (lj_i ? SLOT : SLOT - CW'(1)) : cnt_q == SLOT);
`else
  assign bad_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/i2si_deserializer_gen2.sv
// i2si_deserializer_gen2: parametrised stereo I2S / left-justified input deserializer.
// Define I2SI_FRAME_CHECK_EN to check slot lengths and pulse out_err on framing errors.
module i2si_deserializer_gen2
  import i2si_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_transition,
  input  logic              in_ws,
  input  logic              in_sd,
  input  logic              rf_i2si_en,
  input  logic              rf_mode,
  output logic [DATA_W-1:0] out_lft,
  output logic [DATA_W-1:0] out_rgt,
  output logic              out_xfc,
  output logic              out_err
);
  i2si_state_e state_q;
  logic ws_q, mode_q, l_valid_q, xfc_q, err_q;
  logic [DATA_W-1:0] hold_l_q, lft_q, rgt_q, word;
  logic smp, ws_edge, done, bad;
  always_comb begin
    smp     = sck_transition && rf_i2si_en && state_q != IDLE;
    ws_edge = ws_q != in_ws;
  end
  i2si_slot_capture #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) u_cap (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!rf_i2si_en || state_q == IDLE),
    .smp_i   (smp),
    .sd_i    (in_sd),
    .start_i (ws_edge),
    .lj_i    (mode_q == I2SI_MODE_LJ),
    .done_o  (done),
    .bad_o   (bad),
    .word_o  (word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ws_q      <= 1'b0;
      mode_q    <= I2SI_MODE_I2S;
      l_valid_q <= 1'b0;
      xfc_q     <= 1'b0;
      err_q     <= 1'b0;
      hold_l_q  <= '0;
      lft_q     <= '0;
      rgt_q     <= '0;
    end else begin
      xfc_q <= 1'b0;
      err_q <= 1'b0;
      if (sck_transition) ws_q <= in_ws;
      if (!rf_i2si_en) begin
        state_q   <= IDLE;
        l_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            mode_q  <= rf_mode;
            state_q <= SYNC;
          end
          SYNC: if (smp && ws_edge && !in_ws) state_q <= RUN_L;
          default: if (smp) begin
            if (bad) begin
              err_q     <= 1'b1;
              l_valid_q <= 1'b0;
              state_q   <= SYNC;
            end else begin
              // a word finishing on an I2S edge sample still belongs to the channel being left
              if (done && state_q == RUN_L) begin
                hold_l_q  <= word;
                l_valid_q <= 1'b1;
              end
              if (done && state_q == RUN_R && l_valid_q) begin
                lft_q     <= hold_l_q;
                rgt_q     <= word;
                xfc_q     <= 1'b1;
                l_valid_q <= 1'b0;
              end
              if (ws_edge) state_q <= in_ws ? RUN_R : RUN_L;
            end
          end
        endcase
      end
    end
  end
  assign out_lft = lft_q;
  assign out_rgt = rgt_q;
  assign out_xfc = xfc_q;
  assign out_err = err_q;
endmodule

// File: tb/tb_i2si_deserializer_gen2.sv
// tb_i2si_deserializer_gen2: randomized-stream bench for three parameterisations of the deserializer.
module tb_i2si_deserializer_gen2;
  int checks = 0, fails = 0;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0;
  logic [2:0] ws_v = '0, sd_v = '0, en_v = '0, md_v = '0;
  logic [2:0] xfc_v, err_v;
  logic [15:0] l0, r0, l1, r1;
  logic [23:0] l2, r2;
  bit s_ws[$], s_bit[$], s_tag[$], o_t[$];
  logic o_x[$];
  logic [31:0] e_l[$], e_r[$], o_l[$], o_r[$];
  int gap_x, err_n;
`ifdef I2SI_FRAME_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  always #5 clk = ~clk;

  i2si_deserializer_gen2 #(.DATA_W(16), .SLOT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .sck_transition(sck), .in_ws(ws_v[0]), .in_sd(sd_v[0]),
    .rf_i2si_en(en_v[0]), .rf_mode(md_v[0]), .out_lft(l0), .out_rgt(r0), .out_xfc(xfc_v[0]), .out_err(err_v[0]));
  i2si_deserializer_gen2 #(.DATA_W(16), .SLOT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .sck_transition(sck), .in_ws(ws_v[1]), .in_sd(sd_v[1]),
    .rf_i2si_en(en_v[1]), .rf_mode(md_v[1]), .out_lft(l1), .out_rgt(r1), .out_xfc(xfc_v[1]), .out_err(err_v[1]));
  i2si_deserializer_gen2 #(.DATA_W(24), .SLOT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .sck_transition(sck), .in_ws(ws_v[2]), .in_sd(sd_v[2]),
    .rf_i2si_en(en_v[2]), .rf_mode(md_v[2]), .out_lft(l2), .out_rgt(r2), .out_xfc(xfc_v[2]), .out_err(err_v[2]));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] get_l(int k);
    return k == 0 ? {16'h0, l0} : k == 1 ? {16'h0, l1} : {8'h0, l2};
  endfunction

  function automatic logic [31:0] get_r(int k);
    return k == 0 ? {16'h0, r0} : k == 1 ? {16'h0, r1} : {8'h0, r2};
  endfunction

  function automatic logic [63:0] rnd(int n);
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stream();
    s_ws.delete(); s_bit.delete(); s_tag.delete(); e_l.delete(); e_r.delete();
  endtask

  // one slot of len samples in left-justified alignment, MSB first
  task automatic add_slot(bit w, int len, logic [63:0] v, int tag_at);
    for (int i = 0; i < len; i++) begin
      s_ws.push_back(w);
      s_bit.push_back(v[len-1-i]);
      s_tag.push_back(i == tag_at);
    end
  endtask

  task automatic add_frame(int s, int d, logic [63:0] lv, logic [63:0] rv, bit dlv);
    logic [63:0] m;
    m = (64'd1 << d) - 64'd1;
    add_slot(1'b0, s, lv, -1);
    add_slot(1'b1, s, rv, dlv ? d - 1 : -1);
    if (dlv) begin
      e_l.push_back(32'((lv >> (s - d)) & m));
      e_r.push_back(32'((rv >> (s - d)) & m));
    end
  endtask

  // I2S framing is the LJ stream with data delayed one SCK behind WS
  task automatic play(int k, bit mode, int en_at);
    bit t;
    o_x.delete(); o_t.delete(); o_l.delete(); o_r.delete();
    gap_x = 0;
    err_n = 0;
    for (int i = 0; i < s_ws.size(); i++) begin
      if (i == en_at) begin
        md_v[k] = mode;
        en_v[k] = 1'b1;
        tick();
        md_v[k] = ~mode;
      end
      ws_v[k] = s_ws[i];
      sd_v[k] = mode ? s_bit[i] : (i == 0 ? 1'b0 : s_bit[i-1]);
      t = mode ? s_tag[i] : (i == 0 ? 1'b0 : s_tag[i-1]);
      sck = 1'b1;
      tick();
      sck = 1'b0;
      o_x.push_back(xfc_v[k]);
      o_t.push_back(t);
      o_l.push_back(get_l(k));
      o_r.push_back(get_r(k));
      err_n += int'(err_v[k]);
      repeat ($urandom_range(2)) begin
        tick();
        gap_x += int'(xfc_v[k]);
        err_n += int'(err_v[k]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_l(k) !== 0 || get_r(k) !== 0 || xfc_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset dut%0d: lft=%h rgt=%h xfc=%b err=%b, want all 0", k, get_l(k), get_r(k), xfc_v[k], err_v[k]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i2s16();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 5, rnd(5), -1);
    add_frame(16, 16, 64'h1478, 64'hA3B9, 1'b1);
    repeat (3) add_frame(16, 16, rnd(16), rnd(16), 1'b1);
    add_slot(1'b0, 4, rnd(4), -1);
    en_v[0] = 1'b0;
    repeat (2) tick();
    play(0, 1'b0, 0);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL i2s16 frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0) begin
        fails++;
        $display("FAIL i2s16 sample %0d: xfc=%b, want 0", i, o_x[i]);
      end
    end
    checks++;
    if (gap_x !== 0) begin fails++; $display("FAIL i2s16 gap pulses: %0d, want 0", gap_x); end
  endtask

  task automatic test_lj32();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 5, rnd(5), -1);
    add_frame(32, 16, 64'hCDD7_5555, 64'hBABA_0F0F, 1'b1);
    repeat (2) add_frame(32, 16, rnd(32), rnd(32), 1'b1);
    add_slot(1'b0, 4, rnd(4), -1);
    en_v[1] = 1'b0;
    repeat (2) tick();
    play(1, 1'b1, 0);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL lj32 frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0) begin
        fails++;
        $display("FAIL lj32 sample %0d: xfc=%b, want 0", i, o_x[i]);
      end
    end
    checks++;
    if (gap_x !== 0) begin fails++; $display("FAIL lj32 gap pulses: %0d, want 0", gap_x); end
  endtask

  task automatic test_i2s24_hold();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 7, rnd(7), -1);
    add_frame(32, 24, 64'h7398AB00 | rnd(8), 64'hFFDD0100 | rnd(8), 1'b1);
    repeat (2) add_frame(32, 24, rnd(32), rnd(32), 1'b1);
    add_slot(1'b0, 6, rnd(6), -1);
    en_v[2] = 1'b0;
    repeat (2) tick();
    play(2, 1'b0, 0);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL i2s24 frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0 || (p > 0 && (o_l[i] !== e_l[p-1] || o_r[i] !== e_r[p-1]))) begin
        fails++;
        $display("FAIL i2s24 hold sample %0d: xfc=%b lft=%h rgt=%h", i, o_x[i], o_l[i], o_r[i]);
      end
    end
    checks++;
    if (gap_x !== 0) begin fails++; $display("FAIL i2s24 gap pulses: %0d, want 0", gap_x); end
  endtask

  task automatic test_enable_mid();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 5, rnd(5), -1);
    add_frame(16, 16, rnd(16), rnd(16), 1'b0);
    repeat (2) add_frame(16, 16, rnd(16), rnd(16), 1'b1);
    add_slot(1'b0, 4, rnd(4), -1);
    en_v[0] = 1'b0;
    repeat (2) tick();
    play(0, 1'b0, 5 + 16 + 8);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL enable_mid frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0) begin
        fails++;
        $display("FAIL enable_mid sample %0d: xfc=%b, want 0", i, o_x[i]);
      end
    end
    checks++;
    if (gap_x !== 0) begin fails++; $display("FAIL enable_mid gap pulses: %0d, want 0", gap_x); end
  endtask

  task automatic test_short_slot();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 5, rnd(5), -1);
    add_frame(16, 16, rnd(16), rnd(16), 1'b1);
    add_slot(1'b0, 15, rnd(15), -1);
    add_slot(1'b1, 16, rnd(16), -1);
    add_frame(16, 16, 64'h0001, 64'hFFFF, 1'b1);
    add_slot(1'b0, 4, rnd(4), -1);
    en_v[0] = 1'b0;
    repeat (2) tick();
    play(0, 1'b0, 0);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL short_slot frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0) begin
        fails++;
        $display("FAIL short_slot sample %0d: xfc=%b, want 0", i, o_x[i]);
      end
    end
    checks++;
    if (err_n != EXP_ERR || gap_x !== 0) begin
      fails++;
      $display("FAIL short_slot err pulses=%0d gap xfc=%0d, want err=%0d gap=0", err_n, gap_x, EXP_ERR);
    end
  endtask

  task automatic test_reset_mid();
    int p = 0;
    clear_stream();
    add_slot(1'b1, 5, rnd(5), -1);
    add_frame(16, 16, rnd(16) | 64'h8000, rnd(16) | 64'h1, 1'b1);
    add_slot(1'b0, 7, rnd(7), -1);
    en_v[0] = 1'b0;
    repeat (2) tick();
    play(0, 1'b0, 0);
    checks++;
    if (l0 !== e_l[0][15:0] || r0 !== e_r[0][15:0]) begin
      fails++;
      $display("FAIL reset_mid pre-reset lft=%h rgt=%h, want %h %h", l0, r0, e_l[0], e_r[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (l0 !== 16'h0 || r0 !== 16'h0 || xfc_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid async clear: lft=%h rgt=%h xfc=%b err=%b, want all 0", l0, r0, xfc_v[0], err_v[0]);
    end
    md_v[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_stream();
    add_slot(1'b0, 5, rnd(5), -1);
    add_slot(1'b1, 16, rnd(16), -1);
    repeat (2) add_frame(16, 16, rnd(16), rnd(16), 1'b1);
    add_slot(1'b0, 4, rnd(4), -1);
    play(0, 1'b0, -1);
    foreach (o_x[i]) begin
      checks++;
      if (o_t[i]) begin
        if (o_x[i] !== 1'b1 || o_l[i] !== e_l[p] || o_r[i] !== e_r[p]) begin
          fails++;
          $display("FAIL reset_mid frame %0d: xfc=%b lft=%h rgt=%h, want xfc=1 lft=%h rgt=%h", p, o_x[i], o_l[i], o_r[i], e_l[p], e_r[p]);
        end
        p++;
      end else if (o_x[i] !== 1'b0 || (p == 0 && (o_l[i] !== 0 || o_r[i] !== 0))) begin
        fails++;
        $display("FAIL reset_mid sample %0d: xfc=%b lft=%h rgt=%h", i, o_x[i], o_l[i], o_r[i]);
      end
    end
    checks++;
    if (gap_x !== 0) begin fails++; $display("FAIL reset_mid gap pulses: %0d, want 0", gap_x); end
  endtask

  initial begin
    test_reset();
    test_i2s16();
    test_lj32();
    test_i2s24_hold();
    test_enable_mid();
    test_short_slot();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
